// File: rtl/dilithium_pkg.sv
// Purpose: constants and types shared by the H-function, samplers and NTT blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package dilithium_pkg;

    localparam int Q                   = 8380417;  // Dilithium modulus
    localparam int N                   = 256;      // coefficients per polynomial
    localparam int SHAKE128_RATE_BYTES = 168;      // 56 byte triples per block
    localparam int KECCAK_STATE_W      = 1600;

    typedef logic [22:0] coeff_t;

endpackage

// File: rtl/rej_coeff_check.sv
// Purpose: turn a 3-byte candidate into a 23-bit value and an accept flag (t < BOUND).
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   triple - {b2, b1, b0}, b0 in the low byte
//   t      - candidate value (b2 bit 7 dropped)
//   accept - high when t < BOUND
module rej_coeff_check
    import dilithium_pkg::*;
#(
    parameter int BOUND = Q
) (
    input  logic [23:0] triple,
    output logic [22:0] t,
    output logic        accept
);

    localparam logic [23:0] BOUND_W = 24'(BOUND);

    // The top bit of b2 is not part of the candidate.
    logic unused_top;
    assign unused_top = triple[23];

    assign t      = triple[22:0];
    assign accept = ({1'b0, t} < BOUND_W);

endmodule

// File: rtl/rej_ntt_sampler.sv
// Purpose: rejection-sample SHAKE128 squeeze blocks into the 256 coefficients of one A[i][j].
// Latency: first coefficient 2 cycles after block_valid; one triple per cycle; refill = 2 cycles + producer.
// Backpressure: none downstream; upstream paced by squeeze_req / block_valid handshake.
//
// Ports:
//   start, block_valid, keccak_output          - control pulse and squeezed Keccak state in
//   squeeze_req                                - request for the next squeeze block
//   busy, done                                 - polynomial in progress / finished pulse
//   coeff_valid, coeff, coeff_idx              - accepted coefficient strobe
module rej_ntt_sampler
    import dilithium_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        block_valid,
    input  logic [1599:0] keccak_output,
    output logic        squeeze_req,
    output logic        busy,
    output logic        coeff_valid,
    output logic [22:0] coeff,
    output logic [7:0]  coeff_idx,
    output logic        done
);

    localparam int RATE_W      = SHAKE128_RATE_BYTES * 8;
    localparam int LAST_TRIPLE = SHAKE128_RATE_BYTES / 3 - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_PARSE,
        S_REQ,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [RATE_W-1:0]   rate_buf_q, rate_buf_d;
    logic [5:0]          tidx_q, tidx_d;
    logic [8:0]          cnt_q, cnt_d;       // 9 bits so that reaching N is visible
    logic                coeff_valid_q, coeff_valid_d;
    logic [22:0]         coeff_q, coeff_d;
    logic [7:0]          coeff_idx_q, coeff_idx_d;
    logic                squeeze_req_q, squeeze_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Capacity bits of the Keccak state never feed the sampler.
    logic unused_capacity;
    assign unused_capacity = ^keccak_output[KECCAK_STATE_W-1:RATE_W];

    logic [10:0] bit_ofs;
    logic [23:0] cur_triple;
    logic [22:0] cand_t;
    logic        cand_ok;

    assign bit_ofs    = 11'(tidx_q) * 11'd24;
    assign cur_triple = rate_buf_q[bit_ofs +: 24];

    rej_coeff_check #(
        .BOUND (Q)
    ) u_check (
        .triple (cur_triple),
        .t      (cand_t),
        .accept (cand_ok)
    );

    always_comb begin
        state_d       = state_q;
        rate_buf_d    = rate_buf_q;
        tidx_d        = tidx_q;
        cnt_d         = cnt_q;
        coeff_d       = coeff_q;
        coeff_idx_d   = coeff_idx_q;
        coeff_valid_d = 1'b0;
        squeeze_req_d = 1'b0;
        done_d        = 1'b0;
        busy_d        = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_BLK;
                    cnt_d   = '0;
                    tidx_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT_BLK: begin
                if (block_valid) begin
                    rate_buf_d = keccak_output[RATE_W-1:0];
                    tidx_d     = '0;
                    state_d    = S_PARSE;
                end
            end
            S_PARSE: begin
                if (cand_ok) begin
                    coeff_valid_d = 1'b1;
                    coeff_d       = cand_t;
                    coeff_idx_d   = cnt_q[7:0];
                    cnt_d         = cnt_q + 9'd1;
                end
                // Finishing wins over block exhaustion: leftover triples are dropped.
                if (cand_ok && cnt_d == 9'(N)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (tidx_q == 6'(LAST_TRIPLE)) begin
                    state_d       = S_REQ;
                    squeeze_req_d = 1'b1;
                end else begin
                    tidx_d = tidx_q + 6'd1;
                end
            end
            S_REQ: begin
                // block_valid seen here is ignored; the producer answers later.
                state_d = S_WAIT_BLK;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rate_buf_q    <= '0;
            tidx_q        <= '0;
            cnt_q         <= '0;
            coeff_valid_q <= 1'b0;
            coeff_q       <= '0;
            coeff_idx_q   <= '0;
            squeeze_req_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rate_buf_q    <= rate_buf_d;
            tidx_q        <= tidx_d;
            cnt_q         <= cnt_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_q       <= coeff_d;
            coeff_idx_q   <= coeff_idx_d;
            squeeze_req_q <= squeeze_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign squeeze_req = squeeze_req_q;
    assign busy        = busy_q;
    assign coeff_valid = coeff_valid_q;
    assign coeff       = coeff_q;
    assign coeff_idx   = coeff_idx_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rej_ntt_sampler.sv
// Purpose: randomized scoreboard bench for rej_ntt_sampler against a byte-level RejNTTPoly model.
// Latency: expected coefficient cycles derived from block delivery time.
// Backpressure: bench plays the SHAKE128 producer, answering squeeze_req after a random gap.
module tb_rej_ntt_sampler;
    import dilithium_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          block_valid = 1'b0;
    logic [1599:0] keccak_output = '0;
    logic          squeeze_req;
    logic          busy;
    logic          coeff_valid;
    logic [22:0]   coeff;
    logic [7:0]    coeff_idx;
    logic          done;

    rej_ntt_sampler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .block_valid   (block_valid),
        .keccak_output (keccak_output),
        .squeeze_req   (squeeze_req),
        .busy          (busy),
        .coeff_valid   (coeff_valid),
        .coeff         (coeff),
        .coeff_idx     (coeff_idx),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_sreq = 0;
    int   n_done = 0;
    int   n_cv   = 0;
    int   exp_sreq_cyc = -1;
    int   model_cnt = 0;
    logic prev_done = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and checks request/done timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_done) check(busy == 1'b0, "busy_after_done", int'(busy), 0);
            if (coeff_valid) begin
                n_cv++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_coeff", int'(coeff_idx), -1);
                end else begin
                    e = exp_q.pop_front();
                    check(coeff == 23'(e.val), "coeff_val", int'(coeff), e.val);
                    check(coeff_idx == 8'(e.idx), "coeff_idx", int'(coeff_idx), e.idx);
                    check(cyc == e.cyc, "coeff_cycle", cyc, e.cyc);
                end
            end
            if (squeeze_req) begin
                n_sreq++;
                check(cyc == exp_sreq_cyc, "sreq_cycle", cyc, exp_sreq_cyc);
                exp_sreq_cyc = -1;
            end
            if (done) begin
                n_done++;
                check(coeff_valid && coeff_idx == 8'd255, "done_align", int'(coeff_idx), 255);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // kind 0: zeros, 3: all FF, 4: boundary triples then random, else: mixed random.
    function automatic logic [1599:0] gen_block(input int kind);
        logic [1599:0] b;
        logic [23:0]   tr;
        for (int w = 0; w < 50; w++) b[32*w +: 32] = $urandom;
        for (int k = 0; k < 56; k++) begin
            case (kind)
                0: tr = 24'h000000;
                3: tr = 24'hFFFFFF;
                default: begin
                    case ($urandom_range(0, 3))
                        0: tr = 24'($urandom);
                        1: tr = {1'($urandom), 23'(Q - 3 + int'($urandom_range(0, 6)))};
                        2: tr = {1'($urandom), 23'h7FFF00 | 23'($urandom_range(0, 255))};
                        default: tr = {1'($urandom), 23'($urandom_range(0, 1000))};
                    endcase
                end
            endcase
            b[24*k +: 24] = tr;
        end
        if (kind == 4) begin
            b[0  +: 24] = 24'h7FE000;   // bytes 00,E0,7F -> Q-1, accepted
            b[24 +: 24] = 24'h7FE001;   // bytes 01,E0,7F -> Q, rejected
            b[48 +: 24] = 24'hFFFFFF;   // rejected
            b[72 +: 24] = 24'h800005;   // bytes 05,00,80 -> 5 after masking
        end
        return b;
    endfunction

    // Deliver one block and push the expected coefficients from the byte-level rule.
    task automatic feed(input logic [1599:0] blk, input bit spurious, output bit finished);
        int c;
        int b0, b1, b2, t;
        @(posedge clk); #1;
        block_valid   = 1'b1;
        keccak_output = blk;
        c = cyc;
        for (int k = 0; k < 56 && model_cnt < N; k++) begin
            b0 = int'(blk[8*(3*k)   +: 8]);
            b1 = int'(blk[8*(3*k+1) +: 8]);
            b2 = int'(blk[8*(3*k+2) +: 8]);
            t  = ((b2 & 8'h7F) << 16) | (b1 << 8) | b0;
            if (t < Q) begin
                exp_t e;
                e.cyc = c + 2 + k;
                e.idx = model_cnt;
                e.val = t;
                exp_q.push_back(e);
                model_cnt++;
            end
        end
        finished = (model_cnt == N);
        if (!finished) exp_sreq_cyc = c + 57;
        @(posedge clk); #1;
        keccak_output = gen_block(3);
        if (spurious) begin
            block_valid = 1'b1;
            start       = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        block_valid = 1'b0;
    endtask

    task automatic wait_evt(input bit want_done);
        int base_s;
        int base_d;
        int i;
        base_s = n_sreq;
        base_d = n_done;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            if (want_done ? (n_done != base_d) : (n_sreq != base_s)) break;
        end
        check(i < 300, want_done ? "done_timeout" : "sreq_timeout", i, 300);
    endtask

    task automatic run_poly(input int k0, input int k1, input int kr, input bit spurious);
        bit fin;
        int nb;
        int base_s;
        logic [1599:0] blk;
        model_cnt = 0;
        if (spurious) begin
            @(posedge clk); #1;
            block_valid   = 1'b1;
            keccak_output = gen_block(0);
            @(posedge clk); #1;
            block_valid = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check(busy == 1'b1, "busy_after_start", int'(busy), 1);
        base_s = n_sreq;
        fin = 1'b0;
        nb  = 0;
        while (!fin && nb < 20) begin
            blk = gen_block(nb == 0 ? k0 : (nb == 1 ? k1 : kr));
            feed(blk, spurious && nb == 1, fin);
            nb++;
            wait_evt(fin);
            if (!fin) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        check(n_sreq - base_s == nb - 1, "sreq_count", n_sreq - base_s, nb - 1);
        @(posedge clk);
        @(negedge clk);
        check(exp_q.size() == 0, "missing_coeffs", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(coeff_valid == 1'b0, {tag, "_coeff_valid"}, int'(coeff_valid), 0);
        check(coeff == 23'd0,      {tag, "_coeff"},       int'(coeff), 0);
        check(coeff_idx == 8'd0,   {tag, "_coeff_idx"},   int'(coeff_idx), 0);
        check(done == 1'b0,        {tag, "_done"},        int'(done), 0);
        check(busy == 1'b0,        {tag, "_busy"},        int'(busy), 0);
        check(squeeze_req == 1'b0, {tag, "_squeeze_req"}, int'(squeeze_req), 0);
    endtask

    task automatic reset_mid_parse();
        bit fin;
        int base_cv;
        int base_d;
        int i;
        model_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_cv = n_cv;
        feed(gen_block(1), 1'b0, fin);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_cv - base_cv >= 10) break;
        end
        check(i < 100, "ten_coeff_timeout", i, 100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_outputs_zero("midreset");
        exp_q.delete();
        exp_sreq_cyc = -1;
        base_d = n_done;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check(n_done == base_d, "no_done_after_reset", n_done - base_d, 0);
        check(busy == 1'b0, "idle_after_reset", int'(busy), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_poly(0, 0, 0, 1'b0);   // all-zero blocks: 4 requests, ends at block 5 triple 31
        run_poly(3, 4, 1, 1'b1);   // all-FF block, boundary block, spurious inputs
        run_poly(4, 1, 1, 1'b0);
        reset_mid_parse();
        run_poly(1, 1, 1, 1'b1);   // indices restart at 0 after the abort

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rej_ntt_sampler.md
Name: rej_ntt_sampler

Overview:
- Consumer side of the SHAKE128 H-function. The H-function absorbs rho||j||i and produces the 1600-bit Keccak state on keccak_output.
- This block parses the rate portion of each squeezed state into 23-bit candidates. It keeps only candidates below q and emits 256 coefficients of one matrix entry A[i][j] (RejNTTPoly).
- When a block is exhausted before 256 coefficients are accepted, it requests further squeeze blocks.
- Sits between H_function_top and the coefficient RAM of the ExpandA datapath.

Parameters:
- Q, 8380417, Dilithium modulus; acceptance bound.
- N, 256, coefficients per polynomial.
- RATE_BYTES, 168, SHAKE128 rate in bytes (56 triples per block).
- STATE_W, 1600, Keccak state width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new polynomial.
- block_valid  in  1  one-cycle pulse; keccak_output holds a fresh squeezed state.
- keccak_output  in  1600  Keccak state; byte k = bits [8k+7:8k].
- squeeze_req  out  1  one-cycle pulse requesting the next squeeze block.
- busy  out  1  high from the cycle after start until done.
- coeff_valid  out  1  one-cycle strobe; coeff/coeff_idx valid.
- coeff  out  23  accepted coefficient, 0..Q-1.
- coeff_idx  out  8  index 0..255 of the coefficient.
- done  out  1  one-cycle pulse after coefficient 255 is emitted.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. All outputs 0. Triple index, accept counter and rate buffer cleared. Reset mid-operation aborts the polynomial and emits no done.
- Candidate k (0..55) from buffered bytes b0=byte[3k], b1=byte[3k+1], b2=byte[3k+2]: t = {b2[6:0], b1, b0}. Bit 7 of b2 is discarded. Accept iff t < Q.
- FSM states: IDLE, WAIT_BLK, PARSE, REQ, DONE.
- IDLE:
  - start=1 -> WAIT_BLK. Accept counter and triple index are cleared; busy=1 from the next cycle.
  - start outside IDLE is ignored.
- WAIT_BLK:
  - block_valid=1 -> latch keccak_output[1343:0] into the rate buffer, triple index=0 -> PARSE.
  - block_valid in any other state is ignored.
- PARSE (one triple per cycle):
  - If accepted, register coeff=t, coeff_idx=counter, coeff_valid=1 in the next cycle; counter++.
  - Accepting the 256th coefficient -> DONE. Any remaining triples in the block are discarded.
  - Else if triple index=55 -> REQ.
  - Else triple index++.
- REQ: squeeze_req=1 for exactly one cycle -> WAIT_BLK.
- DONE: done=1 for one cycle, busy=0 from the next cycle -> IDLE. The coeff_valid of coefficient 255 and done fall in the same cycle.
- Latency:
  - First candidate output appears 2 cycles after the block_valid edge (latch, evaluate/register).
  - Worst-case triple throughput is 1/cycle. Each block refill costs 2 cycles (REQ, WAIT_BLK) plus the producer's Keccak latency.
- Counter width: 9 bits internally so that 256 is detectable. coeff_idx = counter[7:0].
- block_valid arriving in the same cycle as squeeze_req is ignored. The producer must respond after the request.

Decomposition:
- Shared package dilithium_pkg:
  - constants Q, N, SHAKE128_RATE_BYTES, KECCAK_STATE_W;
  - typedef coeff_t (23 bits).
  - This package is shared with the H-function and the NTT blocks.
- One natural sub-module, rej_coeff_check: combinational. 24-bit triple in -> 23-bit t plus accept flag. Reused later by ExpandMask/ExpandS samplers with a different bound.

Test Plan:
- All-zero blocks:
  - start, then supply zero states on each squeeze_req.
  - Required: 256 coeff_valid strobes, all coeff=0, idx 0..255 in order.
  - Exactly 4 squeeze_req pulses (blocks 1-4 give 224; block 5 triple 31 gives idx 255).
  - done one cycle wide; busy drops.
- Boundary:
  - Triple 0 bytes 00,E0,7F (t=8380416) -> accepted, coeff=8380416.
  - Triple 1 bytes 01,E0,7F (t=8380417) -> rejected, no strobe.
  - Triple 2 bytes FF,FF,FF (t=8388607) -> rejected.
- Top-bit mask: bytes 05,00,80 -> accepted, coeff=5.
- All-FF block: 56 cycles with no coeff_valid, then one squeeze_req pulse. Counter unchanged.
- Reset mid-PARSE after 10 coefficients:
  - All outputs 0, state IDLE, no done.
  - A new start yields coeff_idx restarting at 0.
- Spurious inputs:
  - block_valid in IDLE/PARSE is ignored (buffer unchanged).
  - start during busy is ignored; the coefficient sequence is unaffected.
